cam_ctrl: RTL and testbench
===========================

Name: cam_ctrl

Overview:
- Sequencing front-end for the 32-entry, 32-bit CAM.
- Accepts one command at a time over a valid/ready interface and drives the CAM enable, index and data pins for the right number of cycles.
- Returns one response per command over a valid/ready interface.
- Tracks entry occupancy and implements INSERT (search, then allocate the lowest free entry on a miss). Sits between client logic and the cam instance.

Parameters:
- WIDTH, 32, data/key width.
- ADDR_WIDTH, 5, index width; the CAM has 2**ADDR_WIDTH entries.
- TIMEOUT, 4, maximum cycles to wait for a CAM valid before reporting an error.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  controller can accept a command.
- cmd_op_i  in  2  operation: 00 READ, 01 WRITE, 10 SEARCH, 11 INSERT.
- cmd_index_i  in  ADDR_WIDTH  entry index for READ/WRITE.
- cmd_data_i  in  WIDTH  write data or search key.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  client accepts the response.
- rsp_hit_o  out  1  SEARCH/INSERT found the key, or READ hit an occupied entry.
- rsp_index_o  out  ADDR_WIDTH  resulting entry index.
- rsp_data_o  out  WIDTH  READ data.
- rsp_err_o  out  1  INSERT into a full CAM, or CAM timeout.
- cam_read_enable_o  out  1  CAM read enable.
- cam_read_index_o  out  ADDR_WIDTH  CAM read index.
- cam_write_enable_o  out  1  CAM write enable.
- cam_write_index_o  out  ADDR_WIDTH  CAM write index.
- cam_write_data_o  out  WIDTH  CAM write data.
- cam_search_enable_o  out  1  CAM search enable.
- cam_search_data_o  out  WIDTH  CAM search key.
- cam_read_valid_i  in  1  CAM read result valid.
- cam_read_value_i  in  WIDTH  CAM read data.
- cam_search_valid_i  in  1  CAM search matched.
- cam_search_index_i  in  ADDR_WIDTH  CAM matched index (lowest match).

Behaviour:
- Reset (rst_i high at an edge):
  - state=IDLE; occupancy bitmap=0; timeout counter=0.
  - All outputs 0, except cmd_ready_o=1 once state is IDLE.
  - A command or response in flight is dropped.
- Handshake:
  - Command accepted on a cycle where cmd_valid_i && cmd_ready_o; op/index/data are registered at that edge.
  - cmd_ready_o=1 only in IDLE.
  - rsp_valid_o holds, with stable fields, until rsp_ready_i.
- CAM strobes are single-cycle pulses, decoded from the state and the registered command. Index/data outputs are 0 when the matching enable is low.
- FSM states: IDLE, ISSUE, WAIT, ALLOC, RESP.
  - IDLE -> ISSUE on command accept.
  - ISSUE, READ: cam_read_enable_o=1 -> WAIT.
  - ISSUE, WRITE: cam_write_enable_o=1; occ[index] set -> RESP with hit=0, index=cmd_index.
  - ISSUE, SEARCH/INSERT: cam_search_enable_o=1 -> WAIT.
  - WAIT, READ: on cam_read_valid_i, capture data; hit=occ[index] -> RESP.
  - WAIT, SEARCH/INSERT: CAM search result is sampled in the cycle after ISSUE.
    - Match with occ[match index] set -> RESP with hit=1, index=match index.
    - Otherwise SEARCH -> RESP with hit=0, index=0.
    - Otherwise INSERT -> ALLOC.
  - WAIT timeout: if no cam_read_valid_i for a READ within TIMEOUT cycles -> RESP with err=1.
  - ALLOC, free entry exists: cam_write_enable_o=1 at the lowest free index; occ bit set -> RESP with hit=0, index=that index.
  - ALLOC, all occupied: no write -> RESP with err=1, index=0.
  - RESP: rsp_valid_o=1; on rsp_ready_i -> IDLE.
- Latency from accept to rsp_valid_o:
  - WRITE: 2 cycles.
  - SEARCH, READ: 3 cycles.
  - INSERT miss: 4 cycles.
- A CAM match on an unoccupied entry counts as a miss (CAM contents are undefined after reset).
- No back-to-back overlap: one command in flight at a time.

Decomposition:
- Package cam_pkg holds:
  - cam_op_e enum (OP_READ, OP_WRITE, OP_SEARCH, OP_INSERT).
  - cam_state_e enum.
  - CAM_WIDTH=32, CAM_ADDR_WIDTH=5, CAM_DEPTH=32.
- Sub-module cam_free_finder: combinational lowest-zero finder over the occupancy bitmap, outputs index and a full flag. Reusable for the CAM's own priority encoder.

Test Plan:
- Reset, then WRITE idx=3 data=0xDEADBEEF -> one cam_write_enable_o pulse with index 3; rsp after 2 cycles, hit=0, index=3, err=0.
- After that, SEARCH 0xDEADBEEF -> cam_search_enable_o pulse; rsp hit=1 index=3. SEARCH 0x12345678 -> hit=0 index=0.
- INSERT 0xA5A5A5A5 into an empty CAM -> write at index 0, rsp hit=0 index=0. Repeat the same INSERT -> hit=1 index=0 with no write pulse.
- Fill all 32 entries via INSERT of keys 0..31, then INSERT 0x100 -> rsp err=1, no cam_write_enable_o.
- READ idx=3 with rsp_ready_i held low for 5 cycles -> rsp_valid_o and data 0xDEADBEEF stable; cmd_ready_o=0 throughout.
- READ with cam_read_valid_i tied 0 -> err=1 after TIMEOUT. Separately, rst_i asserted while in WAIT -> next cycle IDLE, all outputs 0, occupancy cleared (a subsequent SEARCH misses).

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and sizes for the CAM controller slice.
package cam_pkg;
  localparam int CAM_WIDTH      = 32;
  localparam int CAM_ADDR_WIDTH = 5;
  localparam int CAM_DEPTH      = 32;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SEARCH = 2'b10,
    OP_INSERT = 2'b11
  } cam_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ALLOC,
    ST_RESP
  } cam_state_e;
endpackage

// File: rtl/cam_free_finder.sv
// Lowest-zero finder over an occupancy bitmap; purely combinational.
// full_o is set when no bit is clear, free_idx_o is then 0.
module cam_free_finder
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DEPTH,
  parameter int AW    = CAM_ADDR_WIDTH
) (
  input  logic [DEPTH-1:0] occ_i,
  output logic [AW-1:0]    free_idx_o,
  output logic             full_o
);
  // Descending scan so the lowest clear bit is the last one written.
  always_comb begin
    free_idx_o = '0;
    full_o     = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!occ_i[i]) begin
        free_idx_o = AW'(i);
        full_o     = 1'b0;
      end
    end
  end
endmodule

// File: rtl/cam_ctrl.sv
// Single-command sequencer in front of a CAM: WRITE 2, READ/SEARCH 3, INSERT-miss 4 cycles.
// Commands stall (cmd_ready_o low) until the held response is taken by rsp_ready_i.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int WIDTH      = CAM_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_index_i,
  input  logic [WIDTH-1:0]      cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_hit_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  cam_read_enable_o,
  output logic [ADDR_WIDTH-1:0] cam_read_index_o,
  output logic                  cam_write_enable_o,
  output logic [ADDR_WIDTH-1:0] cam_write_index_o,
  output logic [WIDTH-1:0]      cam_write_data_o,
  output logic                  cam_search_enable_o,
  output logic [WIDTH-1:0]      cam_search_data_o,
  input  logic                  cam_read_valid_i,
  input  logic [WIDTH-1:0]      cam_read_value_i,
  input  logic                  cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0] cam_search_index_i
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int TW    = $clog2(TIMEOUT + 1);

  cam_state_e            state_q;
  cam_op_e               op_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [WIDTH-1:0]      data_q;
  logic [DEPTH-1:0]      occ_q;
  logic [TW-1:0]         tmo_q;
  logic                  rsp_valid_q;
  logic                  rsp_hit_q;
  logic                  rsp_err_q;
  logic [ADDR_WIDTH-1:0] rsp_index_q;
  logic [WIDTH-1:0]      rsp_data_q;

  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  full;
  logic                  search_hit;

  cam_free_finder #(.DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_free (
    .occ_i      (occ_q),
    .free_idx_o (free_idx),
    .full_o     (full)
  );

  // CAM contents are unknown after reset, so a match only counts on an occupied entry.
  assign search_hit = cam_search_valid_i && occ_q[cam_search_index_i];

  // Response fields are zero outside RESP, so each transition only sets non-zero fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      idx_q       <= '0;
      data_q      <= '0;
      occ_q       <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            op_q    <= cam_op_e'(cmd_op_i);
            idx_q   <= cmd_index_i;
            data_q  <= cmd_data_i;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_q <= '0;
          if (op_q == OP_WRITE) begin
            occ_q[idx_q] <= 1'b1;
            rsp_valid_q  <= 1'b1;
            rsp_index_q  <= idx_q;
            state_q      <= ST_RESP;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (op_q == OP_READ) begin
            if (cam_read_valid_i) begin
              rsp_valid_q <= 1'b1;
              rsp_hit_q   <= occ_q[idx_q];
              rsp_index_q <= idx_q;
              rsp_data_q  <= cam_read_value_i;
              state_q     <= ST_RESP;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_index_q <= idx_q;
              state_q     <= ST_RESP;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end else if (search_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= 1'b1;
            rsp_index_q <= cam_search_index_i;
            state_q     <= ST_RESP;
          end else if (op_q == OP_SEARCH) begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            state_q <= ST_ALLOC;
          end
        end
        ST_ALLOC: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
          if (!full) begin
            occ_q[free_idx] <= 1'b1;
            rsp_index_q     <= free_idx;
          end else begin
            rsp_err_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_index_q <= '0;
            rsp_data_q  <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cam_read_enable_o   = 1'b0;
    cam_read_index_o    = '0;
    cam_write_enable_o  = 1'b0;
    cam_write_index_o   = '0;
    cam_write_data_o    = '0;
    cam_search_enable_o = 1'b0;
    cam_search_data_o   = '0;
    if (state_q == ST_ISSUE) begin
      case (op_q)
        OP_READ: begin
          cam_read_enable_o = 1'b1;
          cam_read_index_o  = idx_q;
        end
        OP_WRITE: begin
          cam_write_enable_o = 1'b1;
          cam_write_index_o  = idx_q;
          cam_write_data_o   = data_q;
        end
        default: begin
          cam_search_enable_o = 1'b1;
          cam_search_data_o   = data_q;
        end
      endcase
    end else if (state_q == ST_ALLOC && !full) begin
      cam_write_enable_o = 1'b1;
      cam_write_index_o  = free_idx;
      cam_write_data_o   = data_q;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_index_o = rsp_index_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: a behavioural CAM responder plus a spec-level reference model.
module tb_cam_ctrl;
  import cam_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [4:0]  cmd_index_i;
  logic [31:0] cmd_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_hit_o;
  logic [4:0]  rsp_index_o;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        cam_read_enable_o;
  logic [4:0]  cam_read_index_o;
  logic        cam_write_enable_o;
  logic [4:0]  cam_write_index_o;
  logic [31:0] cam_write_data_o;
  logic        cam_search_enable_o;
  logic [31:0] cam_search_data_o;
  logic        cam_read_valid_i;
  logic [31:0] cam_read_value_i;
  logic        cam_search_valid_i;
  logic [4:0]  cam_search_index_i;

  cam_ctrl #(.WIDTH(32), .ADDR_WIDTH(5), .TIMEOUT(TIMEOUT)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .cmd_valid_i         (cmd_valid_i),
    .cmd_ready_o         (cmd_ready_o),
    .cmd_op_i            (cmd_op_i),
    .cmd_index_i         (cmd_index_i),
    .cmd_data_i          (cmd_data_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ready_i         (rsp_ready_i),
    .rsp_hit_o           (rsp_hit_o),
    .rsp_index_o         (rsp_index_o),
    .rsp_data_o          (rsp_data_o),
    .rsp_err_o           (rsp_err_o),
    .cam_read_enable_o   (cam_read_enable_o),
    .cam_read_index_o    (cam_read_index_o),
    .cam_write_enable_o  (cam_write_enable_o),
    .cam_write_index_o   (cam_write_index_o),
    .cam_write_data_o    (cam_write_data_o),
    .cam_search_enable_o (cam_search_enable_o),
    .cam_search_data_o   (cam_search_data_o),
    .cam_read_valid_i    (cam_read_valid_i),
    .cam_read_value_i    (cam_read_value_i),
    .cam_search_valid_i  (cam_search_valid_i),
    .cam_search_index_i  (cam_search_index_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // CAM array contents; survive controller reset like the real macro.
  logic [31:0] mem_m [32];
  bit          written_m [32];
  bit          read_tie0 = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, se_cnt = 0;
  logic [4:0]  last_wi;
  logic [31:0] last_wd;

  // Controller-level expectations.
  logic [31:0] occ_m;
  int          exp_lat, exp_rd, exp_wr, exp_se;
  logic        exp_hit, exp_err;
  logic [4:0]  exp_idx, exp_wi;
  logic [31:0] exp_data, exp_wd;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void lookup(input logic [31:0] key, output bit found, output logic [4:0] j);
    found = 1'b0;
    j     = '0;
    for (int k = 31; k >= 0; k--) begin
      if (written_m[k] && mem_m[k] == key) begin
        found = 1'b1;
        j     = 5'(k);
      end
    end
  endfunction

  always begin : cam_model
    logic        re, we, se;
    logic [4:0]  ri, wi, j;
    logic [31:0] wd, sd;
    bit          found;
    @(negedge clk);
    re = cam_read_enable_o;   ri = cam_read_index_o;
    we = cam_write_enable_o;  wi = cam_write_index_o;  wd = cam_write_data_o;
    se = cam_search_enable_o; sd = cam_search_data_o;
    if (re) rd_cnt++;
    if (se) se_cnt++;
    if (we) begin
      wr_cnt++;
      last_wi = wi;
      last_wd = wd;
    end
    @(posedge clk);
    #1;
    if (we) begin
      mem_m[wi]     = wd;
      written_m[wi] = 1'b1;
    end
    lookup(sd, found, j);
    cam_read_valid_i   = re && !read_tie0;
    cam_read_value_i   = re ? mem_m[ri] : '0;
    cam_search_valid_i = se && found;
    cam_search_index_i = (se && found) ? j : '0;
  end

  task automatic predict(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] key);
    bit         found;
    logic [4:0] j;
    int         f;
    exp_hit = 0; exp_err = 0; exp_idx = '0; exp_data = '0;
    exp_rd = 0; exp_wr = 0; exp_se = 0; exp_wi = '0; exp_wd = '0;
    case (op)
      2'b00: begin
        exp_rd  = 1;
        exp_idx = idx;
        if (read_tie0) begin
          exp_lat = 2 + TIMEOUT;
          exp_err = 1'b1;
        end else begin
          exp_lat  = 3;
          exp_hit  = occ_m[idx];
          exp_data = mem_m[idx];
        end
      end
      2'b01: begin
        exp_lat = 2; exp_idx = idx; exp_wr = 1; exp_wi = idx; exp_wd = key;
        occ_m[idx] = 1'b1;
      end
      default: begin
        exp_se = 1;
        lookup(key, found, j);
        if (found && occ_m[j]) begin
          exp_lat = 3; exp_hit = 1'b1; exp_idx = j;
        end else if (op == 2'b10) begin
          exp_lat = 3;
        end else begin
          exp_lat = 4;
          f = -1;
          for (int k = 31; k >= 0; k--) if (!occ_m[k]) f = k;
          if (f < 0) exp_err = 1'b1;
          else begin
            exp_idx = 5'(f); exp_wr = 1; exp_wi = 5'(f); exp_wd = key;
            occ_m[f] = 1'b1;
          end
        end
      end
    endcase
  endtask

  task automatic check_idle(input string tag);
    check(tag, {cmd_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_data_o, rsp_err_o,
                cam_read_enable_o, cam_read_index_o, cam_write_enable_o, cam_write_index_o,
                cam_write_data_o, cam_search_enable_o, cam_search_data_o},
          {1'b1, 117'b0});
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    occ_m = '0;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] key,
                        input int delay, input string tag);
    int lat;
    bit seen;
    int rd0, wr0, se0;
    predict(op, idx, key);
    rd0 = rd_cnt; wr0 = wr_cnt; se0 = se_cnt;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_index_i = idx; cmd_data_i = key;
    @(negedge clk);
    check({tag, ".cmd_ready"}, cmd_ready_o, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = rsp_valid_o;
    end
    check({tag, ".latency"}, lat, exp_lat);
    if (seen) begin
      check({tag, ".rsp"}, {rsp_hit_o, rsp_index_o, rsp_data_o, rsp_err_o},
            {exp_hit, exp_idx, exp_data, exp_err});
      repeat (delay) begin
        @(negedge clk);
        check({tag, ".hold"},
              {rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_data_o, rsp_err_o, cmd_ready_o},
              {1'b1, exp_hit, exp_idx, exp_data, exp_err, 1'b0});
      end
      rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b0;
      @(negedge clk);
      check({tag, ".drop"}, {rsp_valid_o, cmd_ready_o}, 2'b01);
      check({tag, ".strobes"}, {8'(rd_cnt - rd0), 8'(wr_cnt - wr0), 8'(se_cnt - se0)},
            {8'(exp_rd), 8'(exp_wr), 8'(exp_se)});
      if (exp_wr != 0) check({tag, ".wr_pin"}, {last_wi, last_wd}, {exp_wi, exp_wd});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      mem_m[k] = '0;
      written_m[k] = 1'b0;
    end
    cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_index_i = '0; cmd_data_i = '0;
    rsp_ready_i = 1'b0;
    cam_read_valid_i = 1'b0; cam_read_value_i = '0;
    cam_search_valid_i = 1'b0; cam_search_index_i = '0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    occ_m = '0;
    @(negedge clk);
    check_idle("reset_state");
    @(posedge clk);
    #1;

    do_cmd(OP_WRITE,  5'd3, 32'hDEADBEEF, 0, "write3");
    do_cmd(OP_SEARCH, 5'd0, 32'hDEADBEEF, 0, "search_hit");
    do_cmd(OP_SEARCH, 5'd0, 32'h12345678, 0, "search_miss");
    do_cmd(OP_READ,   5'd3, 32'h0,        5, "read3_bp");
    read_tie0 = 1'b1;
    do_cmd(OP_READ,   5'd3, 32'h0,        0, "read_timeout");

    // Reset while a READ sits in WAIT.
    cmd_valid_i = 1'b1; cmd_op_i = OP_READ; cmd_index_i = 5'd3; cmd_data_i = '0;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    occ_m = '0;
    read_tie0 = 1'b0;
    @(negedge clk);
    check_idle("reset_in_wait");
    @(posedge clk);
    #1;
    do_cmd(OP_SEARCH, 5'd0, 32'hDEADBEEF, 0, "search_after_reset");

    do_cmd(OP_INSERT, 5'd0, 32'hA5A5A5A5, 0, "insert_new");
    do_cmd(OP_INSERT, 5'd0, 32'hA5A5A5A5, 1, "insert_dup");

    do_reset();
    for (int k = 0; k < 32; k++) do_cmd(OP_INSERT, 5'd0, 32'(k), 0, "fill");
    do_cmd(OP_INSERT, 5'd0, 32'h100, 0, "insert_full");

    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  op;
      logic [4:0]  idx;
      logic [31:0] key;
      op  = 2'($urandom_range(0, 3));
      idx = 5'($urandom_range(0, 31));
      key = 32'hC0DE0000 | 32'($urandom_range(0, 7));
      do_cmd(op, idx, key, $urandom_range(0, 2), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
